// File: rtl/fsm_multiplier_scan_if.sv
// -----------------------------------------------------------------------------
// fsm_multiplier_scan_if
// Handshake bundle for the product-scanning big-number multiplier.
//   n_in, m_in   : operand chunk pair (A, B), LSB chunk first
//   valid_in     : operand beat valid
//   mode_in      : 0 = full product, 1 = low half only (taken on first beat)
//   ready_out    : multiplier accepts operand beats
//   data_out     : product chunk, LSB chunk first
//   valid_out    : data_out valid
//   ready_in     : consumer accepts data_out
//   final_out    : marks the last product chunk
// Modports: master = producer/consumer side (bench), slave = multiplier side.
// -----------------------------------------------------------------------------
interface fsm_multiplier_scan_if #(
  parameter int W = 32
);
  logic [W-1:0] n_in;
  logic [W-1:0] m_in;
  logic         valid_in;
  logic         mode_in;
  logic         ready_out;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         ready_in;
  logic         final_out;

  modport master (
    output n_in, m_in, valid_in, mode_in, ready_in,
    input  ready_out, data_out, valid_out, final_out
  );

  modport slave (
    input  n_in, m_in, valid_in, mode_in, ready_in,
    output ready_out, data_out, valid_out, final_out
  );
endinterface

// File: rtl/fsm_multiplier_scan.sv
// -----------------------------------------------------------------------------
// fsm_multiplier_scan
// Big-number multiplier using product scanning: both operands are stored, then
// each output column k is formed by one MAC per cycle, acc += A[i]*B[k-i], and
// the low chunk of the accumulator is emitted before shifting the carry down.
// Ports:
//   clk_in : clock
//   rst_in : asynchronous reset, active high
//   bus    : fsm_multiplier_scan_if.slave (operand input, product output)
// Parameters:
//   REGISTER_SIZE : chunk width W
//   BITS_IN_NUM   : operand width, N = BITS_IN_NUM/REGISTER_SIZE chunks (N >= 2)
// -----------------------------------------------------------------------------
module fsm_multiplier_scan #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  fsm_multiplier_scan_if.slave  bus
);
  localparam int W         = REGISTER_SIZE;
  localparam int N         = BITS_IN_NUM / REGISTER_SIZE;
  localparam int ACC_EXTRA = $clog2(N) + 1;
  // Column sum is at most N*(2^W-1)^2 plus the carry in, which fits here.
  localparam int AW        = 2 * W + ACC_EXTRA;
  localparam int IW        = $clog2(N);
  localparam int KW        = $clog2(2 * N) + 1;

  localparam logic [KW-1:0] LAST_FULL = KW'(2 * N - 1);
  localparam logic [KW-1:0] LAST_LOW  = KW'(N - 1);
  localparam logic [KW-1:0] NM1       = KW'(N - 1);
  localparam logic [IW-1:0] LOAD_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_EMIT    = 2'd3
  } state_t;

  state_t          state_r;
  logic [W-1:0]    a_mem_r [N];
  logic [W-1:0]    b_mem_r [N];
  logic [IW-1:0]   load_idx_r;
  logic [KW-1:0]   k_r;
  logic [IW-1:0]   i_r;
  logic [AW-1:0]   acc_r;
  logic            mode_r;
  logic            ready_out_r;
  logic            valid_out_r;
  logic            final_out_r;
  logic [W-1:0]    data_out_r;

  logic            beat_s;
  logic            handshake_s;
  logic [IW-1:0]   wr_idx_s;
  logic [KW-1:0]   last_col_s;
  logic [KW-1:0]   k_inc_s;
  logic [IW-1:0]   i_hi_s;
  logic [IW-1:0]   i_lo_next_s;
  logic [IW-1:0]   b_idx_s;
  logic [2*W-1:0]  prod_s;
  logic [AW-1:0]   acc_mac_s;
  logic [AW-1:0]   acc_shift_s;

  assign bus.ready_out = ready_out_r;
  assign bus.valid_out = valid_out_r;
  assign bus.final_out = final_out_r;
  assign bus.data_out  = data_out_r;

  // Handshakes, column bounds and MAC datapath.
  always_comb begin
    beat_s      = bus.valid_in && ready_out_r &&
                  ((state_r == ST_IDLE) || (state_r == ST_LOAD));
    handshake_s = valid_out_r && bus.ready_in;
    last_col_s  = mode_r ? LAST_LOW : LAST_FULL;
    k_inc_s     = k_r + KW'(1);
    if (state_r == ST_IDLE) begin
      wr_idx_s = '0;
    end else begin
      wr_idx_s = load_idx_r;
    end
    // Highest term index of column k is min(k, N-1).
    if (k_r > NM1) begin
      i_hi_s = LOAD_LAST;
    end else begin
      i_hi_s = IW'(k_r);
    end
    // Lowest term index of column k+1 is max(0, k+1-(N-1)).
    if (k_inc_s > NM1) begin
      i_lo_next_s = IW'(k_inc_s - NM1);
    end else begin
      i_lo_next_s = '0;
    end
    b_idx_s     = IW'(k_r - KW'(i_r));
    prod_s      = (2*W)'(a_mem_r[i_r]) * (2*W)'(b_mem_r[b_idx_s]);
    acc_mac_s   = acc_r + AW'(prod_s);
    acc_shift_s = acc_r >> W;
  end

  // Operand storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clk_in) begin
    if (beat_s) begin
      a_mem_r[wr_idx_s] <= bus.n_in;
      b_mem_r[wr_idx_s] <= bus.m_in;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      load_idx_r  <= '0;
      k_r         <= '0;
      i_r         <= '0;
      acc_r       <= '0;
      mode_r      <= 1'b0;
      ready_out_r <= 1'b0;
      valid_out_r <= 1'b0;
      final_out_r <= 1'b0;
      data_out_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ready_out_r <= 1'b1;
          valid_out_r <= 1'b0;
          final_out_r <= 1'b0;
          if (beat_s) begin
            mode_r     <= bus.mode_in;
            load_idx_r <= IW'(1);
            state_r    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (beat_s) begin
            if (load_idx_r == LOAD_LAST) begin
              ready_out_r <= 1'b0;
              k_r         <= '0;
              i_r         <= '0;
              state_r     <= ST_COMPUTE;
            end else begin
              load_idx_r <= load_idx_r + IW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          acc_r <= acc_mac_s;
          if (i_r == i_hi_s) begin
            data_out_r  <= acc_mac_s[W-1:0];
            valid_out_r <= 1'b1;
            final_out_r <= (k_r == last_col_s);
            state_r     <= ST_EMIT;
          end else begin
            i_r <= i_r + IW'(1);
          end
        end
        ST_EMIT: begin
          if (handshake_s) begin
            if (k_r == last_col_s) begin
              acc_r       <= '0;
              k_r         <= '0;
              valid_out_r <= 1'b0;
              final_out_r <= 1'b0;
              data_out_r  <= '0;
              ready_out_r <= 1'b1;
              state_r     <= ST_IDLE;
            end else if (k_inc_s == LAST_FULL) begin
              // Top column has no MAC terms: emit the remaining carry directly.
              acc_r       <= acc_shift_s;
              k_r         <= k_inc_s;
              data_out_r  <= acc_shift_s[W-1:0];
              final_out_r <= 1'b1;
            end else begin
              acc_r       <= acc_shift_s;
              k_r         <= k_inc_s;
              i_r         <= i_lo_next_s;
              valid_out_r <= 1'b0;
              final_out_r <= 1'b0;
              state_r     <= ST_COMPUTE;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          acc_r       <= '0;
          valid_out_r <= 1'b0;
          final_out_r <= 1'b0;
          ready_out_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fsm_multiplier_scan.sv
// -----------------------------------------------------------------------------
// tb_fsm_multiplier_scan
// Directed bench for fsm_multiplier_scan with W=8, N=4, followed by a run of
// random back-to-back operations checked against a 64-bit golden product.
// -----------------------------------------------------------------------------
module tb_fsm_multiplier_scan;
  localparam int W    = 8;
  localparam int BITS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fsm_multiplier_scan_if #(.W(W)) bus ();

  fsm_multiplier_scan #(
    .REGISTER_SIZE (W),
    .BITS_IN_NUM   (BITS)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for ready_out, then streams four beats; returns at the negedge after
  // the last beat's sampling edge with valid_in dropped.
  task automatic load_op(input logic [31:0] a, input logic [31:0] b, input logic mode,
                         output int waited);
    waited = 0;
    @(negedge clk);
    while (bus.ready_out !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (bus.ready_out !== 1'b1) check("load_ready_timeout", 64'(bus.ready_out), 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus.n_in     = a[8*i +: 8];
      bus.m_in     = b[8*i +: 8];
      bus.mode_in  = (i == 0) ? mode : ~mode;
      bus.valid_in = 1'b1;
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
  endtask

  // Consumes nbeats product chunks; pat 0 = ready always, 1 = 1-of-3, else random.
  // Returns at the negedge preceding the final handshake edge.
  task automatic collect(input logic [63:0] prod, input int nbeats, input int pat,
                         input string tag);
    int         beat   = 0;
    int         cyc    = 0;
    logic       held_v = 1'b0;
    logic [7:0] held   = 8'h00;
    logic [7:0] exp_b;
    while (beat < nbeats && cyc < 2000) begin
      if (held_v) check({tag, "_stable"}, {55'd0, bus.valid_out, bus.data_out},
                        {55'd0, 1'b1, held});
      case (pat)
        0:       bus.ready_in = 1'b1;
        1:       bus.ready_in = ((cyc % 3) == 0);
        default: bus.ready_in = 1'($urandom_range(0, 1));
      endcase
      if (bus.valid_out === 1'b1) begin
        if (bus.ready_in) begin
          exp_b = prod[8*beat +: 8];
          check($sformatf("%s_data%0d", tag, beat), 64'(bus.data_out), 64'(exp_b));
          check($sformatf("%s_final%0d", tag, beat), 64'(bus.final_out),
                64'(beat == nbeats - 1));
          beat++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = bus.data_out;
        end
      end else begin
        held_v = 1'b0;
      end
      if (beat < nbeats) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (beat < nbeats) check({tag, "_timeout"}, 64'(beat), 64'(nbeats));
  endtask

  // After the last beat: no extra beat, ready_out back high one cycle later.
  task automatic post_idle(input string tag);
    @(negedge clk);
    check({tag, "_no_extra"}, 64'(bus.valid_out), 64'd0);
    check({tag, "_ready_back"}, 64'(bus.ready_out), 64'd1);
  endtask

  initial begin
    int          waited;
    int          spurious;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rm;
    logic [63:0] golden;

    bus.n_in = 8'h00; bus.m_in = 8'h00; bus.valid_in = 1'b0;
    bus.mode_in = 1'b0; bus.ready_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_final", 64'(bus.final_out), 64'd0);
    check("rst_data",  64'(bus.data_out),  64'd0);
    check("rst_ready", 64'(bus.ready_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(bus.ready_out), 64'd1);

    // Case 1: FFFFFFFF^2 full product, with first-output latency
    bus.ready_in = 1'b0;
    load_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, waited);
    check("c1_t1_valid", 64'(bus.valid_out), 64'd0);
    check("c1_t1_ready", 64'(bus.ready_out), 64'd0);
    @(negedge clk);
    check("c1_t2_valid", 64'(bus.valid_out), 64'd1);
    collect(64'hFFFF_FFFE_0000_0001, 8, 0, "c1");
    bus.ready_in = 1'b1;
    post_idle("c1");

    // Case 2: 1 * DEADBEEF, operand noise on valid_in during compute
    load_op(32'h0000_0001, 32'hDEAD_BEEF, 1'b0, waited);
    bus.valid_in = 1'b1; bus.n_in = 8'h55; bus.m_in = 8'hAA;
    collect(64'h0000_0000_DEAD_BEEF, 8, 0, "c2");
    bus.valid_in = 1'b0;
    post_idle("c2");

    // Case 3: low-half mode
    load_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, waited);
    collect(64'hFFFF_FFFE_0000_0001, 4, 0, "c3");
    post_idle("c3");

    // Case 4: case 1 with ready_in high one cycle in three
    load_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, waited);
    collect(64'hFFFF_FFFE_0000_0001, 8, 1, "c4");
    bus.ready_in = 1'b1;
    post_idle("c4");

    // Case 5: reset during a stalled emit (async drop) and during compute
    bus.ready_in = 1'b0;
    load_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, waited);
    @(negedge clk);
    check("c5_pre_valid", 64'(bus.valid_out), 64'd1);
    #2 rst = 1'b1;
    #1 check("c5_async_valid", 64'(bus.valid_out), 64'd0);
    check("c5_async_final", 64'(bus.final_out), 64'd0);
    check("c5_async_ready", 64'(bus.ready_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.ready_in = 1'b1;
    load_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, waited);
    #2 rst = 1'b1;
    #1 check("c5_comp_valid", 64'(bus.valid_out), 64'd0);
    check("c5_comp_data", 64'(bus.data_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.valid_out !== 1'b0) spurious++;
    end
    check("c5_no_beats", 64'(spurious), 64'd0);
    load_op(32'h0000_0001, 32'hDEAD_BEEF, 1'b0, waited);
    collect(64'h0000_0000_DEAD_BEEF, 8, 0, "c5");
    post_idle("c5");

    // Case 6: random back-to-back operations
    for (int op = 0; op < 200; op++) begin
      ra = $urandom();
      rb = $urandom();
      rm = 1'($urandom_range(0, 1));
      golden = {32'd0, ra} * {32'd0, rb};
      load_op(ra, rb, rm, waited);
      check($sformatf("c6_gap%0d", op), 64'(waited), 64'd0);
      collect(golden, rm ? 4 : 8, (op % 2 == 0) ? 0 : 2, $sformatf("c6_op%0d", op));
      bus.ready_in = 1'b1;
    end
    post_idle("c6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
